// File: rtl/bus_pkg.sv
// Shared types and constants for the fx68k bus-cycle controller and its address decoder.
package bus_pkg;

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned CS_W   = 5;

    localparam int unsigned CS_ROM  = 0;
    localparam int unsigned CS_RAM  = 1;
    localparam int unsigned CS_CHAR = 2;
    localparam int unsigned CS_ACIA = 3;
    localparam int unsigned CS_LED  = 4;

    typedef enum logic [2:0] {
        RegionRom,
        RegionRam,
        RegionChar,
        RegionAcia,
        RegionLed,
        RegionNone
    } region_e;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAck,
        StVpa,
        StTmo,
        StBerr
    } state_e;

    function automatic logic [CS_W-1:0] region_cs(region_e r);
        logic [CS_W-1:0] sel;
        sel = '0;
        case (r)
            RegionRom:  sel[CS_ROM]  = 1'b1;
            RegionRam:  sel[CS_RAM]  = 1'b1;
            RegionChar: sel[CS_CHAR] = 1'b1;
            RegionAcia: sel[CS_ACIA] = 1'b1;
            RegionLed:  sel[CS_LED]  = 1'b1;
            default:    sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_decode.sv
// Combinational region decode of CPU address bits [15:12]; shared with the top-level data mux.
module bus_decode
    import bus_pkg::*;
(
    input  logic [3:0] addr_hi,
    output region_e    region
);

    always_comb begin
        region = RegionNone;
        unique case (addr_hi)
            4'h0:    region = RegionRom;
            4'h1:    region = RegionRam;
            4'h2:    region = RegionChar;
            4'h3:    region = RegionAcia;
            4'h4:    region = RegionLed;
            default: region = RegionNone;
        endcase
    end

endmodule

// File: rtl/bus_ctrl.sv
// fx68k bus-cycle controller: registered chip selects, per-region wait states, DTACK/VPA/BERR.
// Define BUS_TIMEOUT_EN to enable the bus-error timeout on unmapped accesses.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned ROM_WAIT  = 1,
    parameter int unsigned RAM_WAIT  = 1,
    parameter int unsigned CHAR_WAIT = 1,
    parameter int unsigned LED_WAIT  = 0,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            as_n,
    input  logic            rw,
    input  logic            uds_n,
    input  logic            lds_n,
    input  logic [23:1]     addr,
    output logic [CS_W-1:0] cs,
    output logic [1:0]      we,
    output logic            dtack_n,
    output logic            vpa_n,
    output logic            berr_n
);

    localparam logic [WAIT_W-1:0] ROM_CNT  = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_CNT  = WAIT_W'(RAM_WAIT);
    localparam logic [WAIT_W-1:0] CHAR_CNT = WAIT_W'(CHAR_WAIT);
    localparam logic [WAIT_W-1:0] LED_CNT  = WAIT_W'(LED_WAIT);
`ifdef BUS_TIMEOUT_EN
    localparam logic [TMO_W-1:0]  UNMAPPED_CNT = TMO_W'(TIMEOUT);
`else
    // Without the timeout path an unmapped access acks like a zero-wait region.
    localparam logic [TMO_W-1:0]  UNMAPPED_CNT = TMO_W'(TIMEOUT * 0);
`endif

    region_e          region;
    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic [1:0]       we_q, we_d;
    logic             dtack_n_q, dtack_n_d;
    logic             vpa_n_q, vpa_n_d;
    logic             berr_n_q, berr_n_d;
    logic             unused_addr;

    assign unused_addr = ^{addr[23:16], addr[11:1]};

    bus_decode u_decode (
        .addr_hi (addr[15:12]),
        .region  (region)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!as_n) begin
                    unique case (region)
                        RegionRom:  begin state_d = StWait; cnt_d = TMO_W'(ROM_CNT);  end
                        RegionRam:  begin state_d = StWait; cnt_d = TMO_W'(RAM_CNT);  end
                        RegionChar: begin state_d = StWait; cnt_d = TMO_W'(CHAR_CNT); end
                        RegionLed:  begin state_d = StWait; cnt_d = TMO_W'(LED_CNT);  end
                        RegionAcia: state_d = StVpa;
`ifdef BUS_TIMEOUT_EN
                        RegionNone: begin state_d = StTmo;  cnt_d = UNMAPPED_CNT; end
`else
                        RegionNone: begin state_d = StWait; cnt_d = UNMAPPED_CNT; end
`endif
                        default:    state_d = StIdle;
                    endcase
                end
            end
            StWait: begin
                if (as_n) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - TMO_W'(1);
                end
            end
`ifdef BUS_TIMEOUT_EN
            StTmo: begin
                if (as_n) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StBerr;
                end else begin
                    cnt_d = cnt_q - TMO_W'(1);
                end
            end
            StBerr: if (as_n) state_d = StIdle;
`endif
            StAck:   if (as_n) state_d = StIdle;
            StVpa:   if (as_n) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs_d = cs_q;
        we_d = '0;
        if (state_d == StIdle) begin
            cs_d = '0;
        end else if (state_q == StIdle) begin
            cs_d = region_cs(region);
        end
        // cs_q is zero only for unmapped cycles, whose writes are dropped.
        if (state_d == StAck && state_q != StAck && !rw && (cs_q != '0)) begin
            we_d = {!uds_n, !lds_n};
        end
        dtack_n_d = (state_d != StAck);
        // VPA trails the select by one cycle, so it needs a full cycle spent in StVpa.
        vpa_n_d   = !(state_q == StVpa && state_d == StVpa);
        berr_n_d  = (state_d != StBerr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q      <= '0;
            we_q      <= '0;
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            cs_q      <= cs_d;
            we_q      <= we_d;
            dtack_n_q <= dtack_n_d;
            vpa_n_q   <= vpa_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    assign cs      = cs_q;
    assign we      = we_q;
    assign dtack_n = dtack_n_q;
    assign vpa_n   = vpa_n_q;
    assign berr_n  = berr_n_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed table-driven bench for bus_ctrl; expectations follow BUS_TIMEOUT_EN if defined.
module tb_bus_ctrl;

    typedef struct {
        string       name;
        logic        as_n;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
        logic [23:0] baddr;
        logic [4:0]  cs;
        logic [1:0]  we;
        logic        dtack_n;
        logic        vpa_n;
        logic        berr_n;
    } vec_t;

    localparam logic [9:0] RST_OUT = {5'b00000, 2'b00, 3'b111};

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n, rw, uds_n, lds_n;
    logic [23:1] addr;
    logic [4:0]  cs;
    logic [1:0]  we;
    logic        dtack_n, vpa_n, berr_n;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    vec_t        tbl[$];

    bus_ctrl #(
        .ROM_WAIT  (1),
        .RAM_WAIT  (5),
        .CHAR_WAIT (1),
        .LED_WAIT  (0),
        .TIMEOUT   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .as_n    (as_n),
        .rw      (rw),
        .uds_n   (uds_n),
        .lds_n   (lds_n),
        .addr    (addr),
        .cs      (cs),
        .we      (we),
        .dtack_n (dtack_n),
        .vpa_n   (vpa_n),
        .berr_n  (berr_n)
    );

    always #20 clk = ~clk;

    task automatic row(input string name, input logic a, input logic r, input logic u,
                       input logic l, input logic [23:0] ba, input logic [4:0] c,
                       input logic [1:0] w, input logic d, input logic v, input logic b);
        vec_t t;
        t.name = name; t.as_n = a; t.rw = r; t.uds_n = u; t.lds_n = l; t.baddr = ba;
        t.cs = c; t.we = w; t.dtack_n = d; t.vpa_n = v; t.berr_n = b;
        tbl.push_back(t);
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) row(name, 1, 1, 1, 1, 24'h0, 5'b0, 2'b0, 1, 1, 1);
    endtask

    task automatic drive(input logic a, input logic r, input logic u, input logic l,
                         input logic [23:0] ba);
        as_n = a; rw = r; uds_n = u; lds_n = l; addr = ba[23:1];
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {cs, we, dtack_n, vpa_n, berr_n};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got cs=%b we=%b dtack_n=%b vpa_n=%b berr_n=%b, want cs=%b we=%b dtack_n=%b vpa_n=%b berr_n=%b",
                     name, $time, got[9:5], got[4:3], got[2], got[1], got[0],
                     exp[9:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step_check(input string name, input logic [9:0] exp);
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        // ROM read 0x0004, W=1
        idle("idle0", 2);
        row("rom_cs", 0, 1, 0, 0, 24'h000004, 5'b00001, 2'b00, 1, 1, 1);
        row("rom_w1", 0, 1, 0, 0, 24'h000004, 5'b00001, 2'b00, 1, 1, 1);
        row("rom_ack", 0, 1, 0, 0, 24'h000004, 5'b00001, 2'b00, 0, 1, 1);
        row("rom_hold", 0, 1, 0, 0, 24'h000004, 5'b00001, 2'b00, 0, 1, 1);
        idle("rom_rel", 2);
        // RAM word write 0x1002, W=5
        row("ram_cs", 0, 0, 0, 0, 24'h001002, 5'b00010, 2'b00, 1, 1, 1);
        for (int i = 0; i < 5; i++) row("ram_wait", 0, 0, 0, 0, 24'h001002, 5'b00010, 2'b00, 1, 1, 1);
        row("ram_we", 0, 0, 0, 0, 24'h001002, 5'b00010, 2'b11, 0, 1, 1);
        row("ram_we_end", 0, 0, 0, 0, 24'h001002, 5'b00010, 2'b00, 0, 1, 1);
        idle("ram_rel", 1);
        // char RAM lower-byte write, W=1
        row("chr_cs", 0, 0, 1, 0, 24'h002000, 5'b00100, 2'b00, 1, 1, 1);
        row("chr_w1", 0, 0, 1, 0, 24'h002000, 5'b00100, 2'b00, 1, 1, 1);
        row("chr_we", 0, 0, 1, 0, 24'h002000, 5'b00100, 2'b01, 0, 1, 1);
        row("chr_we_end", 0, 0, 1, 0, 24'h002000, 5'b00100, 2'b00, 0, 1, 1);
        idle("chr_rel", 1);
        // LED upper-byte write, W=0
        row("led_cs", 0, 0, 0, 1, 24'h004000, 5'b10000, 2'b00, 1, 1, 1);
        row("led_we", 0, 0, 0, 1, 24'h004000, 5'b10000, 2'b10, 0, 1, 1);
        row("led_we_end", 0, 0, 0, 1, 24'h004000, 5'b10000, 2'b00, 0, 1, 1);
        idle("led_rel", 1);
        // ACIA write: VPA only, never DTACK or we
        row("acia_cs", 0, 0, 0, 0, 24'h003000, 5'b01000, 2'b00, 1, 1, 1);
        row("acia_vpa", 0, 0, 0, 0, 24'h003000, 5'b01000, 2'b00, 1, 0, 1);
        row("acia_hold", 0, 0, 0, 0, 24'h003000, 5'b01000, 2'b00, 1, 0, 1);
        row("acia_hold", 0, 0, 0, 0, 24'h003000, 5'b01000, 2'b00, 1, 0, 1);
        idle("acia_rel", 1);
        // abort a RAM write mid-wait
        for (int i = 0; i < 4; i++) row("abort_wait", 0, 0, 0, 0, 24'h001000, 5'b00010, 2'b00, 1, 1, 1);
        idle("abort_idle", 5);
        // unmapped read 0x5000
`ifdef BUS_TIMEOUT_EN
        row("unm_cs", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 1, 1, 1);
        for (int i = 0; i < 8; i++) row("unm_tmo", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 1, 1, 1);
        row("unm_berr", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 1, 1, 0);
        row("unm_berr_hold", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 1, 1, 0);
`else
        row("unm_cs", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 1, 1, 1);
        row("unm_ack", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 0, 1, 1);
        row("unm_hold", 0, 1, 0, 0, 24'h005000, 5'b00000, 2'b00, 0, 1, 1);
`endif
        idle("unm_rel", 2);

        reset = 1'b1;
        drive(1, 1, 1, 1, 24'h0);
        #1;
        check("reset_state", RST_OUT);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].as_n, tbl[i].rw, tbl[i].uds_n, tbl[i].lds_n, tbl[i].baddr);
            step_check(tbl[i].name, {tbl[i].cs, tbl[i].we, tbl[i].dtack_n, tbl[i].vpa_n,
                                     tbl[i].berr_n});
        end

        // asynchronous reset while in ACK, then a clean follow-up cycle
        drive(0, 1, 0, 0, 24'h000004);
        step_check("rst_seq_cs", {5'b00001, 2'b00, 3'b111});
        step_check("rst_seq_w1", {5'b00001, 2'b00, 3'b111});
        step_check("rst_seq_ack", {5'b00001, 2'b00, 3'b011});
        #10;
        reset = 1'b1;
        #1;
        check("async_reset", RST_OUT);
        drive(1, 1, 1, 1, 24'h0);
        #5;
        reset = 1'b0;
        step_check("post_reset_idle", RST_OUT);
        drive(0, 1, 0, 0, 24'h000004);
        step_check("clean_cs", {5'b00001, 2'b00, 3'b111});
        step_check("clean_w1", {5'b00001, 2'b00, 3'b111});
        step_check("clean_ack", {5'b00001, 2'b00, 3'b011});
        drive(1, 1, 1, 1, 24'h0);
        step_check("clean_rel", RST_OUT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Bus-cycle controller for the fx68k CPU bus. It replaces the free-running DTACK flop and the combinational chip-select logic in `top`. Per cycle it decodes the address, drives registered one-hot chip selects, and inserts per-region wait states before DTACK. It asserts VPA for the 6800-style ACIA cycle, emits single-cycle byte write strobes, and signals a bus error on unmapped accesses. It sits between the fx68k bus pins and the ROM, work RAM, char RAM, ACIA and LED register.

## Interface
- `ROM_WAIT`, 1: wait cycles before DTACK for ROM, 0–15.
- `RAM_WAIT`, 1: wait cycles for work RAM, 0–15.
- `CHAR_WAIT`, 1: wait cycles for char RAM, 0–15.
- `LED_WAIT`, 0: wait cycles for the LED register, 0–15.
- `TIMEOUT`, 200: cycles before BERR on an unmapped access, 1–255.
- `clk`  in  1  system clock (25 MHz); one clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `as_n`  in  1  CPU address strobe.
- `rw`  in  1  1 = read, 0 = write.
- `uds_n`, `lds_n`  in  1 each  upper/lower data strobes.
- `addr`  in  23  CPU address [23:1]; decode uses [15:12].
- `cs`  out  5  registered one-hot select, {led, acia, char_ram, ram, rom}.
- `we`  out  2  byte write strobes {upper, lower}, one-cycle pulse.
- `dtack_n`  out  1  data transfer acknowledge.
- `vpa_n`  out  1  valid peripheral address (ACIA only).
- `berr_n`  out  1  bus error.

## Operation
- Region map on addr[15:12]:
  - 0 → ROM
  - 1 → RAM
  - 2 → char RAM
  - 3 → ACIA
  - 4 → LED
  - 5–F → unmapped
- FSM states: IDLE, WAIT, ACK, VPA, TMO, BERR.
- IDLE, `as_n` sampled low:
  - Latch the region and set the matching `cs` bit (none for unmapped).
  - Mapped memory or LED: load the wait counter from the region parameter and go to WAIT.
  - ACIA: go to VPA.
  - Unmapped: load the timeout counter with TIMEOUT and go to TMO.
- WAIT: counter==0 → ACK; otherwise decrement.
- ACK: `dtack_n`=0. On ACK entry only, if `rw`=0, `we`={!uds_n,!lds_n} for exactly one cycle; `we`=0 at all other times.
- VPA: `vpa_n`=0 until the cycle ends. The ACIA's own E-clock logic performs the access; `we` stays 0.
- TMO: decrement the counter each cycle; at 0 → BERR, `berr_n`=0.
- Cycle end: `as_n` sampled high in any non-IDLE state → IDLE. `cs`, `dtack_n`, `vpa_n` and `berr_n` are negated after that same edge.
- Abort: `as_n` rising in WAIT or TMO returns to IDLE with no DTACK, no BERR and no `we` pulse.
- Back-to-back cycles: `as_n` must be seen high for at least one edge between cycles. A new cycle starts only from IDLE.

## Timing
- Reset values: `cs`=0, `we`=0, `dtack_n`=1, `vpa_n`=1, `berr_n`=1, state IDLE. Reset applies immediately (asynchronous) and also mid-cycle.
- `as_n` low sampled at edge N:
  - `cs` valid after N.
  - `dtack_n` low after N+1+W, where W is the region wait count. W=0 gives DTACK one cycle after select.
  - `we` pulse spans edges N+1+W to N+2+W.
- ROM and RAM have 1-cycle read latency, so W≥1 is required for valid read data; W=0 is legal only for LED.
- VPA path: `vpa_n` low after N+1.
- Unmapped path: `berr_n` low after N+1+TIMEOUT.
- Outputs release one edge after `as_n` is sampled high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `BUS_TIMEOUT_EN` defined: the TMO/BERR path is as described above.
- `BUS_TIMEOUT_EN` undefined: TMO and BERR are removed.
  - Unmapped accesses are acknowledged like a W=0 region with `cs`=0. Read data is whatever the top-level mux supplies; writes are discarded.
  - `berr_n` is held at 1 and the TIMEOUT parameter is ignored.

## Structure
- Shared package `bus_pkg`:
  - region enum (ROM, RAM, CHAR, ACIA, LED, NONE);
  - FSM state enum;
  - `CS_*` bit-index constants;
  - wait-counter width (4) and timeout-counter width (8).
- One sub-module, `bus_decode`: combinational addr[15:12] → region enum. It is reused by the top-level data-bus mux.

## Test plan
- Read 0x0004 with ROM_WAIT=1, `as_n` low at edge 0 → `cs`=00001 after edge 0, `dtack_n` low after edge 2, all outputs released one edge after `as_n` is high.
- Word write to 0x1002, `uds_n`=`lds_n`=0 → `cs`=00010, `we`=11 for exactly one cycle coincident with `dtack_n` falling; byte write with `lds_n` only → `we`=01.
- Access to 0x3000 → `cs`=01000, `vpa_n` low after edge 1, `dtack_n` stays 1, `we`=0 even with `rw`=0.
- Access to 0x5000 with TIMEOUT=8, macro defined → `berr_n` low after edge 9, `dtack_n` stays 1. Macro undefined → `dtack_n` low after edge 1, `berr_n`=1.
- Abort: `as_n` returns high during WAIT (RAM_WAIT=5, released at edge 3) → no `dtack_n`, no `we`, state IDLE after edge 4.
- Assert `reset` during ACK → all outputs at reset values immediately; the next `as_n` low starts a clean cycle.
